uart_frame_rx: RTL
==================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter BYTE_GAP, default 16'd20000, maximum clk cycles allowed between two bytes of one frame.
REQ-003 SHALL have parameter LINK_TIMEOUT, default 24'd6500000 (100 ms at 65 MHz), cycles without a good frame before the link is declared lost.
REQ-004 SHALL have parameters PL2_X_RST, default 12'd974, and PL2_Y_RST, default 12'd679, the player-2 position held from reset.
REQ-005 SHALL have port clk, input, 1, the 65 MHz pixel/system clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx_data, input, 8, byte from the UART receiver.
REQ-008 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-009 SHALL have port pl2_posx, output, 12, last accepted player-2 x.
REQ-010 SHALL have port pl2_posy, output, 12, last accepted player-2 y.
REQ-011 SHALL have port frame_valid, output, 1, one-cycle pulse on each accepted frame.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on each discarded frame.
REQ-013 SHALL have port link_ok, output, 1, high while good frames arrive within LINK_TIMEOUT.

Function
REQ-014 SHALL parse 6-byte frames: SYNC, XH, XL, YH, YL, CHK; x={XH[3:0],XL}, y={YH[3:0],YL}; CHK = XH^XL^YH^YL.
REQ-015 SHALL use an FSM with states HUNT, XH, XL, YH, YL, CHK, each advancing only on rx_valid.
REQ-016 In HUNT, SHALL ignore every byte except SYNC_BYTE, which moves the FSM to XH.
REQ-017 In data states, a byte equal to SYNC_BYTE SHALL be taken as data (no resync mid-frame).
REQ-018 SHALL discard the frame (frame_err pulse, return to HUNT) when XH[7:4] or YH[7:4] is nonzero, checked at that byte.
REQ-019 On the CHK byte, SHALL on checksum match update pl2_posx/pl2_posy and pulse frame_valid in the cycle after the CHK strobe; on mismatch SHALL pulse frame_err in that cycle and leave positions unchanged; either way it SHALL return to HUNT.
REQ-020 SHALL never update pl2_posx or pl2_posy partially; both change in the same cycle or neither changes.
REQ-021 SHALL keep a gap counter, cleared on every rx_valid, counting while the FSM is not in HUNT; reaching BYTE_GAP SHALL abort to HUNT with a frame_err pulse.
REQ-022 SHALL keep a link counter, cleared on frame_valid and saturating at LINK_TIMEOUT; link_ok = (counter < LINK_TIMEOUT).
REQ-023 When a good frame completes in the same cycle the link counter would saturate, the clear SHALL win and link_ok SHALL stay high.
REQ-024 When rx_valid coincides with a gap timeout, the byte SHALL be processed and the timeout ignored.
REQ-025 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-026 While rst is low, SHALL force FSM=HUNT, pl2_posx=PL2_X_RST, pl2_posy=PL2_Y_RST, frame_valid=0, frame_err=0, gap counter=0, link counter=LINK_TIMEOUT (link_ok=0).
REQ-027 A reset asserted mid-frame SHALL drop the partial frame with no frame_err pulse.

Configuration
REQ-028 With macro UART_FRAME_RX_RANGE_CHECK_EN defined, a checksum-correct frame with x>1023 or y>767 SHALL be discarded with a frame_err pulse; without it, every checksum-correct frame is accepted.

Verification
REQ-029 After reset release, send A5 03 CE 02 A7 CHK=68 -> pl2_posx=974 unchanged until the cycle after CHK, then 12'h3CE=974... use A5 01 F4 02 A7 50 -> pl2_posx=500, pl2_posy=679, one frame_valid pulse, link_ok=1.
REQ-030 Send A5 01 F4 02 A7 51 (bad CHK) -> frame_err pulse, positions unchanged.
REQ-031 Send 00 33 A5 00 A5 02 00 A7 -> leading junk ignored, A5 in XL taken as data, pl2_posx=165, pl2_posy=512 (CHK=A7^A5^02^00... computed by bench).
REQ-032 Send A5 01 then idle BYTE_GAP cycles -> frame_err pulse, FSM in HUNT; next full good frame accepted.
REQ-033 One good frame, then no traffic for LINK_TIMEOUT cycles -> link_ok falls exactly LINK_TIMEOUT cycles after frame_valid; positions held.
REQ-034 With UART_FRAME_RX_RANGE_CHECK_EN: frame x=1024 (XH=04, XL=00) -> frame_err; without it -> accepted, pl2_posx=1024.

Source files
------------

// File: rtl/uart_frame_rx_if.sv
// Byte-stream input and player-2 position/status outputs of the UART frame receiver.
// The slave side is the receiver. The master side is whoever feeds bytes and watches the results.
interface uart_frame_rx_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] pl2_posx;
  logic [11:0] pl2_posy;
  logic        frame_valid;
  logic        frame_err;
  logic        link_ok;

  modport master (
    output rx_data, rx_valid,
    input  pl2_posx, pl2_posy, frame_valid, frame_err, link_ok
  );

  modport slave (
    input  rx_data, rx_valid,
    output pl2_posx, pl2_posy, frame_valid, frame_err, link_ok
  );
endinterface

// File: rtl/uart_frame_rx.sv
// Parses 6-byte SYNC/XH/XL/YH/YL/CHK frames into player-2 x/y; results are registered one cycle after CHK.
// Defining UART_FRAME_RX_RANGE_CHECK_EN additionally rejects frames with x>1023 or y>767.
module uart_frame_rx #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [15:0] BYTE_GAP     = 16'd20000,
  parameter logic [23:0] LINK_TIMEOUT = 24'd6500000,
  parameter logic [11:0] PL2_X_RST    = 12'd974,
  parameter logic [11:0] PL2_Y_RST    = 12'd679
) (
  input logic            clk,
  input logic            rst,
  uart_frame_rx_if.slave bus
);

  typedef enum logic [2:0] {HUNT, XH, XL, YH, YL, CHK} state_t;

  state_t      state, state_nxt;
  logic [7:0]  x_hi, x_lo, y_hi, y_lo;
  logic [15:0] gap_cnt;
  logic [23:0] link_cnt;
  logic [11:0] posx, posy;
  logic        fv, fe, fv_nxt, fe_nxt;
  logic [11:0] x_cand, y_cand;
  logic [7:0]  chk_calc;
  logic        range_bad, gap_hit;

  assign x_cand   = {x_hi[3:0], x_lo};
  assign y_cand   = {y_hi[3:0], y_lo};
  assign chk_calc = x_hi ^ x_lo ^ y_hi ^ y_lo;
  assign gap_hit  = (state != HUNT) && (gap_cnt >= BYTE_GAP);

`ifdef UART_FRAME_RX_RANGE_CHECK_EN
  assign range_bad = (x_cand > 12'd1023) || (y_cand > 12'd767);
`else
  assign range_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
      fv    <= 1'b0;
      fe    <= 1'b0;
    end else begin
      state <= state_nxt;
      fv    <= fv_nxt;
      fe    <= fe_nxt;
    end
  end

  // A byte arriving in the same cycle as the gap expiry takes precedence over the abort.
  always_comb begin
    state_nxt = state;
    fv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    if (bus.rx_valid) begin
      case (state)
        HUNT: if (bus.rx_data == SYNC_BYTE) state_nxt = XH;
        XH: begin
          if (bus.rx_data[7:4] != 4'd0) begin
            state_nxt = HUNT;
            fe_nxt    = 1'b1;
          end else begin
            state_nxt = XL;
          end
        end
        XL: state_nxt = YH;
        YH: begin
          if (bus.rx_data[7:4] != 4'd0) begin
            state_nxt = HUNT;
            fe_nxt    = 1'b1;
          end else begin
            state_nxt = YL;
          end
        end
        YL: state_nxt = CHK;
        CHK: begin
          state_nxt = HUNT;
          if ((bus.rx_data == chk_calc) && !range_bad) fv_nxt = 1'b1;
          else                                         fe_nxt = 1'b1;
        end
        default: state_nxt = HUNT;
      endcase
    end else if (gap_hit) begin
      state_nxt = HUNT;
      fe_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_hi <= 8'd0;
      x_lo <= 8'd0;
      y_hi <= 8'd0;
      y_lo <= 8'd0;
    end else if (bus.rx_valid) begin
      case (state)
        XH:      x_hi <= bus.rx_data;
        XL:      x_lo <= bus.rx_data;
        YH:      y_hi <= bus.rx_data;
        YL:      y_lo <= bus.rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= 16'd0;
    end else if (bus.rx_valid || (state == HUNT)) begin
      gap_cnt <= 16'd0;
    end else if (gap_cnt < BYTE_GAP) begin
      gap_cnt <= gap_cnt + 16'd1;
    end
  end

  // Clearing on the accept decision keeps link_ok high even if saturation would land on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      link_cnt <= LINK_TIMEOUT;
    end else if (fv_nxt) begin
      link_cnt <= 24'd0;
    end else if (link_cnt < LINK_TIMEOUT) begin
      link_cnt <= link_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      posx <= PL2_X_RST;
      posy <= PL2_Y_RST;
    end else if (fv_nxt) begin
      posx <= x_cand;
      posy <= y_cand;
    end
  end

  assign bus.pl2_posx    = posx;
  assign bus.pl2_posy    = posy;
  assign bus.frame_valid = fv;
  assign bus.frame_err   = fe;
  assign bus.link_ok     = (link_cnt < LINK_TIMEOUT);

endmodule
